// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: the state encoding and
// the default word width and gap length.
package serial_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_GAP_CYC = 1;

endpackage

// File: rtl/serial_pattern_tx.sv
// Parallel-to-serial transmitter. It sends an MSB-first frame of programmable
// length with an enable strobe, then holds a fixed idle gap before the next handshake.
module serial_pattern_tx
  import serial_tx_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int GAP_CYC = DEF_GAP_CYC,
  parameter int LEN_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din_vld,
  input  logic [DATA_W-1:0] din,
  input  logic [LEN_W-1:0]  din_len,
  output logic              din_rdy,
  output logic              enable,
  output logic              datain,
  output logic              done,
  output logic              busy
);

  // The counter is shared between the bit index and the gap length, so it must hold either.
  localparam int CNT_W = (LEN_W > 4) ? LEN_W : 4;
  localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;

  state_t            state_q, state_nxt;
  logic [DATA_W-1:0] shreg_q, shreg_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic              enable_d, datain_d, done_d, din_rdy_d, busy_d;
  logic              accept;

  // Index of the last bit to send. A length of 0, or one beyond the word, selects the full word.
  function automatic logic [CNT_W-1:0] last_idx(input logic [LEN_W-1:0] len);
    if (len == '0 || int'(len) > DATA_W) return CNT_W'(DATA_W - 1);
    return CNT_W'(int'(len) - 1);
  endfunction

  assign accept = din_vld & din_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      enable  <= 1'b0;
      datain  <= 1'b0;
      done    <= 1'b0;
      din_rdy <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      shreg_q <= shreg_nxt;
      cnt_q   <= cnt_nxt;
      enable  <= enable_d;
      datain  <= datain_d;
      done    <= done_d;
      din_rdy <= din_rdy_d;
      busy    <= busy_d;
    end
  end

  always_comb begin
    state_nxt = state_q;
    shreg_nxt = shreg_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_SHIFT;
          shreg_nxt = din;
          cnt_nxt   = last_idx(din_len);
        end
      end
      ST_SHIFT: begin
        if (cnt_q == '0) begin
          shreg_nxt = '0;
          if (GAP_CYC > 0) begin
            state_nxt = ST_GAP;
            cnt_nxt   = GAP_LAST;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          shreg_nxt = {shreg_q[DATA_W-2:0], 1'b0};
          cnt_nxt   = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) state_nxt = ST_IDLE;
        else             cnt_nxt   = cnt_q - CNT_W'(1);
      end
      default: begin
        state_nxt = ST_IDLE;
        shreg_nxt = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are derived from the upcoming state so that their registers line up with it.
  always_comb begin
    enable_d  = (state_nxt == ST_SHIFT);
    datain_d  = enable_d & shreg_nxt[DATA_W-1];
    done_d    = enable_d & (cnt_nxt == '0);
    din_rdy_d = (state_nxt == ST_IDLE);
    busy_d    = (state_nxt != ST_IDLE);
  end

endmodule
